// File: rtl/keypad_pkg.sv
// Shared keypad/game definitions: key codes, controller states, result codes
// and the secret clamp used when latching a three-digit BCD secret.
package keypad_pkg;

  localparam logic [3:0] KEY_ENTER = 4'hA;
  localparam logic [3:0] KEY_BACK  = 4'hB;
  localparam logic [3:0] KEY_CLEAR = 4'hC;

  typedef enum logic [2:0] {
    ST_ENTRY  = 3'd0,
    ST_CHECK  = 3'd1,
    ST_RESULT = 3'd2,
    ST_WIN    = 3'd3,
    ST_LOSE   = 3'd4
  } game_state_t;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_LOW  = 2'b01,
    RES_HIGH = 2'b10,
    RES_EQ   = 2'b11
  } result_t;

  // Keys 0-9 are digits; A-F are commands or ignored.
  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  // Forces every nibble into BCD range so the comparator only ever sees
  // legal digits: a digit above 9 becomes 9.
  function automatic logic [11:0] clamp_bcd3(input logic [11:0] value);
    logic [11:0] clamped;
    logic [3:0]  digit;
    clamped = '0;
    for (int i = 0; i < 3; i++) begin
      digit = value[i*4 +: 4];
      clamped[i*4 +: 4] = (digit > 4'd9) ? 4'd9 : digit;
    end
    return clamped;
  endfunction

endpackage

// File: rtl/guess_game_ctrl_if.sv
// Key-in / display-out bundle of the guessing-game controller. The master
// side is the keypad decoder plus display path, the slave side the controller.
interface guess_game_ctrl_if;

  logic        key_valid;
  logic [3:0]  key_code;
  logic [11:0] secret;

  logic [11:0] data;
  logic [3:0]  tries;
  logic [1:0]  entry_len;
  logic [1:0]  result;
  logic        win;
  logic        lose;

  modport master (
    output key_valid, key_code, secret,
    input  data, tries, entry_len, result, win, lose
  );

  modport slave (
    input  key_valid, key_code, secret,
    output data, tries, entry_len, result, win, lose
  );

endinterface

// File: rtl/bcd3_compare.sv
// Combinational magnitude compare of two three-digit packed BCD values.
// With every nibble at most 9, MSD-first digit order is the same as the
// unsigned order of the packed 12-bit words, so a plain compare suffices.
module bcd3_compare (
  input  logic [11:0] i_a,
  input  logic [11:0] i_b,
  output logic        o_lt,
  output logic        o_eq,
  output logic        o_gt
);

  // NOTE: continuous assigns give every output a value on every path, so no
  // storage can be inferred here.
  assign o_lt = (i_a <  i_b);
  assign o_eq = (i_a == i_b);
  assign o_gt = (i_a >  i_b);

endmodule

// File: rtl/guess_game_ctrl.sv
// Guessing-game controller: builds a three-digit BCD entry from keypad
// strobes, scores each submission against a latched secret, holds the
// HIGH/LOW verdict for RESULT_HOLD cycles and tracks win/lose.
module guess_game_ctrl
  import keypad_pkg::*;
#(
  parameter int MAX_TRIES   = 9,
  parameter int RESULT_HOLD = 50_000_000
) (
  input  logic              clk,
  input  logic              RST,
  guess_game_ctrl_if.slave  bus
);

  localparam int               HOLD_W    = $clog2(RESULT_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESULT_HOLD - 1);
  localparam logic [3:0]       TRIES_MAX = 4'(MAX_TRIES);

  game_state_t       r_state;
  result_t           r_result;
  logic [11:0]       r_data;
  logic [11:0]       r_secret;
  logic [3:0]        r_tries;
  logic [1:0]        r_entry_len;
  logic              r_win;
  logic              r_lose;
  logic [HOLD_W-1:0] r_hold_cnt;

  logic w_lt;
  logic w_eq;
  logic w_gt;
  logic w_clear;

  // C restarts the game from any state, same as reset.
  assign w_clear = bus.key_valid && (bus.key_code == KEY_CLEAR);

  bcd3_compare u_cmp (
    .i_a  (r_data),
    .i_b  (r_secret),
    .o_lt (w_lt),
    .o_eq (w_eq),
    .o_gt (w_gt)
  );

  // Game FSM with all outputs registered; reset and C share one clear path.
  always_ff @(posedge clk) begin
    // NOTE: every state register uses non-blocking assignment, so all
    // updates in this block see the pre-edge values regardless of order.
    if (RST || w_clear) begin
      r_state     <= ST_ENTRY;
      r_result    <= RES_NONE;
      r_data      <= '0;
      r_tries     <= '0;
      r_entry_len <= '0;
      r_win       <= 1'b0;
      r_lose      <= 1'b0;
      r_hold_cnt  <= '0;
      r_secret    <= clamp_bcd3(bus.secret);
    end else begin
      case (r_state)
        ST_ENTRY: begin
          if (bus.key_valid) begin
            if (is_digit(bus.key_code)) begin
              if (r_entry_len != 2'd3) begin
                r_data      <= {r_data[7:0], bus.key_code};
                r_entry_len <= r_entry_len + 2'd1;
              end
            end else if (bus.key_code == KEY_BACK) begin
              if (r_entry_len != 2'd0) begin
                r_data      <= {4'h0, r_data[11:4]};
                r_entry_len <= r_entry_len - 2'd1;
              end
            end else if (bus.key_code == KEY_ENTER) begin
              if (r_entry_len != 2'd0) begin
                r_state <= ST_CHECK;
                r_tries <= r_tries + 4'd1;
              end
            end
          end
        end

        ST_CHECK: begin
          if (w_eq) begin
            r_result <= RES_EQ;
            r_win    <= 1'b1;
            r_state  <= ST_WIN;
          end else begin
            r_result <= w_lt ? RES_LOW : RES_HIGH;
            if (r_tries == TRIES_MAX) begin
              r_lose  <= 1'b1;
              r_data  <= r_secret;
              r_state <= ST_LOSE;
            end else begin
              r_hold_cnt <= HOLD_LOAD;
              r_state    <= ST_RESULT;
            end
          end
        end

        ST_RESULT: begin
          if (r_hold_cnt == '0) begin
            r_state     <= ST_ENTRY;
            r_data      <= '0;
            r_entry_len <= '0;
            r_result    <= RES_NONE;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end

        ST_WIN, ST_LOSE: begin
          // Hold the final display until C.
        end

        default: r_state <= ST_ENTRY;
      endcase
    end
  end

  assign bus.data      = r_data;
  assign bus.tries     = r_tries;
  assign bus.entry_len = r_entry_len;
  assign bus.result    = r_result;
  assign bus.win       = r_win;
  assign bus.lose      = r_lose;

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl with MAX_TRIES=3, RESULT_HOLD=4.
// Stimulus changes and outputs are sampled on the falling clock edge.
module tb_guess_game_ctrl;

  logic clk = 1'b0;
  logic RST;
  int   errors = 0;
  int   checks = 0;

  guess_game_ctrl_if bus();

  guess_game_ctrl #(
    .MAX_TRIES   (3),
    .RESULT_HOLD (4)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // One strobe, consumed by the next rising edge; returns on the falling edge after it.
  task automatic press(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  // Two strobes on consecutive cycles.
  task automatic press2(input logic [3:0] k1, input logic [3:0] k2);
    bus.key_valid = 1'b1;
    bus.key_code  = k1;
    @(negedge clk);
    bus.key_code  = k2;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [21:0] snap;
    bus.secret    = 12'h472;
    RST           = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd5;
    @(negedge clk);
    RST           = 1'b0;
    bus.key_valid = 1'b0;
    snap = {bus.data, bus.tries, bus.entry_len, bus.result, bus.win, bus.lose};
    checks++; if (snap !== 22'h0) begin errors++; $display("FAIL reset_outputs got=%h want=0", snap); end
    press(4'd3);
    checks++; if (bus.data !== 12'h003) begin errors++; $display("FAIL pre_rst_digit data=%h want=003", bus.data); end
    RST           = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'd8;
    @(negedge clk);
    RST           = 1'b0;
    bus.key_valid = 1'b0;
    snap = {bus.data, bus.tries, bus.entry_len, bus.result, bus.win, bus.lose};
    checks++; if (snap !== 22'h0) begin errors++; $display("FAIL rst_over_key got=%h want=0", snap); end
  endtask

  task automatic test_entry_edit();
    press(4'd1); press(4'd2); press(4'd3);
    checks++; if (bus.data !== 12'h123) begin errors++; $display("FAIL entry_three data=%h want=123", bus.data); end
    checks++; if (bus.entry_len !== 2'd3) begin errors++; $display("FAIL entry_three_len got=%0d want=3", bus.entry_len); end
    press(4'd4);
    checks++; if (bus.data !== 12'h123 || bus.entry_len !== 2'd3) begin errors++; $display("FAIL entry_full data=%h len=%0d want=123/3", bus.data, bus.entry_len); end
    press(4'hB);
    checks++; if (bus.data !== 12'h012 || bus.entry_len !== 2'd2) begin errors++; $display("FAIL back_one data=%h len=%0d want=012/2", bus.data, bus.entry_len); end
    press(4'hB); press(4'hB); press(4'hB);
    checks++; if (bus.data !== 12'h000 || bus.entry_len !== 2'd0) begin errors++; $display("FAIL back_empty data=%h len=%0d want=000/0", bus.data, bus.entry_len); end
    press(4'hA);
    idle(2);
    checks++; if (bus.tries !== 4'd0 || bus.result !== 2'b00) begin errors++; $display("FAIL enter_empty tries=%0d result=%b want=0/00", bus.tries, bus.result); end
    press(4'hE);
    checks++; if (bus.data !== 12'h000 || bus.entry_len !== 2'd0) begin errors++; $display("FAIL key_e_ignored data=%h len=%0d want=000/0", bus.data, bus.entry_len); end
    press2(4'd4, 4'd7);
    checks++; if (bus.data !== 12'h047 || bus.entry_len !== 2'd2) begin errors++; $display("FAIL back_to_back data=%h len=%0d want=047/2", bus.data, bus.entry_len); end
    press2(4'hB, 4'hB);
    checks++; if (bus.data !== 12'h000 || bus.entry_len !== 2'd0) begin errors++; $display("FAIL b2b_back data=%h len=%0d want=000/0", bus.data, bus.entry_len); end
  endtask

  task automatic test_compare_hold();
    press(4'd5); press(4'd0); press(4'd0); press(4'hA);
    checks++; if (bus.tries !== 4'd1 || bus.result !== 2'b00) begin errors++; $display("FAIL check_cycle tries=%0d result=%b want=1/00", bus.tries, bus.result); end
    idle(1);
    checks++; if (bus.result !== 2'b10) begin errors++; $display("FAIL high_result got=%b want=10", bus.result); end
    press(4'd9);
    checks++; if (bus.data !== 12'h500) begin errors++; $display("FAIL result_ignores_digit data=%h want=500", bus.data); end
    idle(2);
    checks++; if (bus.result !== 2'b10) begin errors++; $display("FAIL hold_last_cycle result=%b want=10", bus.result); end
    idle(1);
    checks++; if (bus.result !== 2'b00 || bus.data !== 12'h000 || bus.entry_len !== 2'd0) begin errors++; $display("FAIL hold_exit result=%b data=%h len=%0d want=00/000/0", bus.result, bus.data, bus.entry_len); end
    checks++; if (bus.tries !== 4'd1) begin errors++; $display("FAIL hold_exit_tries got=%0d want=1", bus.tries); end
  endtask

  task automatic test_win();
    press2(4'd4, 4'd7); press(4'd2); press(4'hA);
    idle(1);
    checks++; if (bus.result !== 2'b11 || bus.win !== 1'b1 || bus.lose !== 1'b0) begin errors++; $display("FAIL win_flags result=%b win=%b lose=%b want=11/1/0", bus.result, bus.win, bus.lose); end
    checks++; if (bus.data !== 12'h472 || bus.tries !== 4'd2) begin errors++; $display("FAIL win_data data=%h tries=%0d want=472/2", bus.data, bus.tries); end
    press(4'd5);
    checks++; if (bus.data !== 12'h472 || bus.entry_len !== 2'd3) begin errors++; $display("FAIL win_ignores_digit data=%h len=%0d want=472/3", bus.data, bus.entry_len); end
    press(4'hC);
    checks++; if (bus.tries !== 4'd0 || bus.win !== 1'b0 || bus.data !== 12'h000 || bus.result !== 2'b00) begin errors++; $display("FAIL win_clear tries=%0d win=%b data=%h result=%b want=0/0/000/00", bus.tries, bus.win, bus.data, bus.result); end
  endtask

  task automatic test_lose();
    bus.secret = 12'h010;
    press(4'hC);
    press(4'd0); press(4'd0); press(4'd9); press(4'hA);
    idle(1);
    checks++; if (bus.result !== 2'b01) begin errors++; $display("FAIL lose_g1 result=%b want=01", bus.result); end
    idle(4);
    press(4'd0); press(4'd1); press(4'd1); press(4'hA);
    idle(1);
    checks++; if (bus.result !== 2'b10) begin errors++; $display("FAIL lose_g2 result=%b want=10", bus.result); end
    idle(4);
    press(4'd0); press(4'd0); press(4'd5); press(4'hA);
    checks++; if (bus.tries !== 4'd3) begin errors++; $display("FAIL lose_g3_tries got=%0d want=3", bus.tries); end
    idle(1);
    checks++; if (bus.lose !== 1'b1 || bus.win !== 1'b0 || bus.result !== 2'b01) begin errors++; $display("FAIL lose_flags lose=%b win=%b result=%b want=1/0/01", bus.lose, bus.win, bus.result); end
    checks++; if (bus.data !== 12'h010) begin errors++; $display("FAIL lose_shows_secret data=%h want=010", bus.data); end
    press(4'd7);
    idle(3);
    checks++; if (bus.lose !== 1'b1 || bus.data !== 12'h010 || bus.tries !== 4'd3) begin errors++; $display("FAIL lose_hold lose=%b data=%h tries=%0d want=1/010/3", bus.lose, bus.data, bus.tries); end
  endtask

  task automatic test_abort();
    bus.secret = 12'hF3A;
    press(4'hC);
    checks++; if (bus.lose !== 1'b0 || bus.tries !== 4'd0 || bus.data !== 12'h000) begin errors++; $display("FAIL clear_from_lose lose=%b tries=%0d data=%h want=0/0/000", bus.lose, bus.tries, bus.data); end
    press(4'd5); press(4'hA);
    press(4'hC);
    checks++; if (bus.result !== 2'b00 || bus.tries !== 4'd0 || bus.data !== 12'h000 || bus.win !== 1'b0) begin errors++; $display("FAIL clear_in_check result=%b tries=%0d data=%h win=%b want=00/0/000/0", bus.result, bus.tries, bus.data, bus.win); end
    press(4'd1); press(4'hA);
    idle(1);
    checks++; if (bus.result !== 2'b01) begin errors++; $display("FAIL low_vs_939 result=%b want=01", bus.result); end
    press(4'hC);
    checks++; if (bus.result !== 2'b00 || bus.tries !== 4'd0 || bus.entry_len !== 2'd0) begin errors++; $display("FAIL clear_in_result result=%b tries=%0d len=%0d want=00/0/0", bus.result, bus.tries, bus.entry_len); end
    press(4'd9); press(4'd9); press(4'd9); press(4'hA);
    idle(1);
    checks++; if (bus.result !== 2'b10) begin errors++; $display("FAIL high_vs_939 result=%b want=10", bus.result); end
    idle(3);
    checks++; if (bus.result !== 2'b10) begin errors++; $display("FAIL full_hold_after_abort result=%b want=10", bus.result); end
    idle(1);
    checks++; if (bus.result !== 2'b00) begin errors++; $display("FAIL hold_end_after_abort result=%b want=00", bus.result); end
    press(4'd1); press(4'hA);
    idle(5);
    press(4'd2); press(4'hA);
    idle(1);
    checks++; if (bus.lose !== 1'b1 || bus.data !== 12'h939) begin errors++; $display("FAIL secret_clamp lose=%b data=%h want=1/939", bus.lose, bus.data); end
  endtask

  initial begin
    RST           = 1'b1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
    bus.secret    = 12'h472;
    @(negedge clk);
    test_reset();
    test_entry_edit();
    test_compare_hold();
    test_win();
    test_lose();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/guess_game_ctrl.md
# guess_game_ctrl

Controller that turns debounced keypad key codes into a three-digit BCD entry and scores each entry against a latched secret. It drives the `data` and `tries` inputs of the digitron display path. It sits between the one-hot-to-binary key decoder (`cur_binary` plus a new-key strobe) and `Digitron_TimeDisplay_module`. It owns all sequencing: digit entry, edit, submit, compare, result hold, win/lose and restart.

## Interface
- `MAX_TRIES`, default 9: number of submissions allowed before LOSE (1..15).
- `RESULT_HOLD`, default 50_000_000: cycles the HIGH/LOW result is shown before returning to entry (1 s at 50 MHz, ≥1).
- `clk` input 1: system clock (50 MHz).
- `RST` input 1: reset. Synchronous and active-high; one clock only.
- `key_valid` input 1: single-cycle strobe, one new debounced key press.
- `key_code` input 4: key value, valid when `key_valid`=1. 0–9 digit, A enter, B backspace, C clear/new game, D–F ignored.
- `secret` input 12: three packed BCD digits, MSD in [11:8]. Sampled on reset and on C.
- `data` output 12: BCD value for the display. Entry buffer in ENTRY/RESULT/WIN; the secret in LOSE.
- `tries` output 4: binary count of submissions in the current game.
- `entry_len` output 2: digits currently in the entry buffer (0–3).
- `result` output 2: 00 none, 01 LOW (guess < secret), 10 HIGH (guess > secret), 11 EQUAL.
- `win` output 1: high in WIN state.
- `lose` output 1: high in LOSE state.

## Operation
- States: ENTRY, CHECK, RESULT, WIN, LOSE.
- Reset: ENTRY, `data`=0, `entry_len`=0, `tries`=0, `result`=00, `win`=`lose`=0. Secret latched from `secret`.
- Secret latch: any digit >9 is replaced by 9 when latched.
- ENTRY, digit key:
  - If `entry_len`<3: `data`←{`data`[7:0], digit}, `entry_len`+1.
  - If `entry_len`=3: ignored.
- ENTRY, B: if `entry_len`>0, `data`←{4'h0, `data`[11:4]}, `entry_len`−1. Otherwise ignored.
- ENTRY, A: if `entry_len`=0, ignored. Otherwise go to CHECK and set `tries`←`tries`+1.
- CHECK (exactly 1 cycle): compare `data` with the secret as unsigned packed BCD. Digit-wise MSD-first order equals numeric order.
  - Equal: `result`=11, go to WIN.
  - Else if `tries`=`MAX_TRIES`: `result`=01/10, go to LOSE.
  - Else: `result`=01/10, go to RESULT and load the hold counter.
- RESULT: counts `RESULT_HOLD` cycles, then returns to ENTRY with `data`=0, `entry_len`=0, `result`=00.
- WIN: `data` keeps the guess. LOSE: `data` shows the secret. Both hold until C.
- C in any state, including CHECK and RESULT:
  - Go to ENTRY; clear `data`, `entry_len`, `tries`, `result`, `win`, `lose`.
  - Relatch the secret and reset the hold counter.
- Keys other than C in CHECK, RESULT, WIN or LOSE are ignored.
- D–F are ignored in every state.
- `tries` never exceeds `MAX_TRIES`; LOSE is entered on the `MAX_TRIES`-th wrong guess.

## Timing
- All outputs are registered and change on the clk edge after the `key_valid` cycle; key-to-`data` latency is 1 cycle.
- A: cycle n strobe → cycle n+1 CHECK, `tries` updated → cycle n+2 in RESULT/WIN/LOSE with `result` valid.
- RESULT lasts exactly `RESULT_HOLD` cycles. The ENTRY clear takes effect on the following edge.
- Back-to-back `key_valid` strobes on consecutive cycles are each processed, subject to the state rules above.
- `RST` overrides everything, including a same-cycle `key_valid`.

## Structure
- Shared package `keypad_pkg`:
  - Key code constants: KEY_ENTER=4'hA, KEY_BACK=4'hB, KEY_CLEAR=4'hC.
  - State encoding.
  - Result codes RES_NONE, RES_LOW, RES_HIGH, RES_EQ.
- Sub-module `bcd3_compare`: combinational; takes two 12-bit BCD values and outputs lt/eq/gt. Reused by later display/game blocks.
- Counters: hold counter sized by $clog2(`RESULT_HOLD`+1); `tries` fixed at 4 bits.

## Test plan
- Use `RESULT_HOLD`=4 and `MAX_TRIES`=3 in the bench.
- Entry/edit: secret=12'h472; keys 1,2,3,4 → `data`=12'h123, `entry_len`=3. B → `data`=12'h012, `entry_len`=2. B,B,B → `data`=0, `entry_len`=0. A with empty entry → stays ENTRY, `tries`=0.
- Compare/hold: enter 5,0,0,A → `tries`=1, `result`=10 two cycles after the A strobe. After 4 RESULT cycles → ENTRY, `data`=0, `result`=00.
- Win: secret=12'h472; enter 4,7,2,A → `result`=11, `win`=1, `data`=12'h472. Digit keys ignored. C → ENTRY, `tries`=0, `win`=0.
- Lose: secret=12'h010; guesses 009, 011, 005 → after the third, `lose`=1, `tries`=3, `data`=12'h010, `result`=01.
- Abort/reset: C during RESULT → ENTRY next cycle with hold counter cleared. Secret input 12'hF3A → latched as 12'h939. `RST` asserted with a concurrent digit strobe → all outputs 0.
